lock_ctrl: RTL and testbench
============================

# lock_ctrl

Sequencing controller for the three-digit lock box password datapath. It turns debounced ENTER presses into a create or unlock sequence. It drives the slot index and one-cycle write strobe that load the three 3-bit password registers, then compares switch entries against their read-back values. It sits between the board I/O (switches, button, mode switch) and the password registers, and produces the unlock and lockout indications for the display/actuator logic.

## Interface
- OPEN_CYCLES, 500_000_000: cycles UNLOCKED stays high (5 s at 100 MHz)
- LOCKOUT_CYCLES, 1_000_000_000: lockout duration in cycles
- MAX_FAILS, 3: consecutive failed attempts that trigger lockout

- CLK  in  1  system clock; one clock domain
- RST_N  in  1  reset, asynchronous, active-low
- SW  in  3  digit switches (static while ENTER pressed)
- ENTER  in  1  debounced enter button, level
- CREATE  in  1  create-mode switch
- PW1, PW2, PW3  in  3 each  stored password digits read back from registers
- SLOT  out  2  active digit slot, 1..3; 0 when idle
- WR_EN  out  1  one-cycle password register write strobe
- UNLOCKED  out  1  lock open
- FAIL  out  1  one-cycle pulse on rejected attempt
- LOCKED_OUT  out  1  lockout active
- PW_VALID  out  1  a password has been created since reset

## Operation
- Press = rising edge of ENTER (ENTER registered; edge register resets to 0). Presses not described below are ignored.
- States: IDLE, DIGIT, CHECK, OPEN, LOCKOUT.
- IDLE:
  - A press starts a sequence. The mode is latched from CREATE at that press and held until the sequence ends.
  - A create sequence is allowed only if PW_VALID=0.
  - An unlock sequence is allowed only if PW_VALID=1. Disallowed presses are ignored.
  - The starting press consumes digit 1. SLOT goes to 1 and the state goes to DIGIT.
- DIGIT, create mode:
  - Each consumed digit press produces WR_EN=1 for exactly one cycle, with SLOT holding that digit's index.
  - SLOT then advances. After slot 3 is written: PW_VALID<=1 and the state returns to IDLE.
- DIGIT, unlock mode:
  - Each press compares SW with PW[SLOT]. Any mismatch sets a sticky mismatch flag.
  - All three digits are always collected; there is no early rejection.
  - After digit 3 the state goes to CHECK.
- CHECK (one cycle):
  - No mismatch: go to OPEN and clear the fail counter.
  - Mismatch: FAIL pulse, increment the fail counter (saturating), return to IDLE.
- OPEN:
  - UNLOCKED=1 and the timer counts OPEN_CYCLES, then the state returns to IDLE.
  - A press with CREATE=1 starts a create sequence, leaving OPEN (UNLOCKED drops). This is the only way to re-create once PW_VALID=1.
  - A press with CREATE=0 relocks immediately (to IDLE).
- LOCKOUT: see Configuration.
- CREATE toggling mid-sequence has no effect. RST_N low at any point returns to IDLE with all outputs cleared; partial sequences are discarded.

## Timing
- Reset values: SLOT=0, WR_EN=0, UNLOCKED=0, FAIL=0, LOCKED_OUT=0, PW_VALID=0; fail counter, timer and mismatch flag = 0.
- ENTER rising at edge N is detected at edge N+1. WR_EN and SLOT are registered and valid in cycle N+1 to N+2. WR_EN is never high for two consecutive cycles.
- Unlock: FAIL or UNLOCKED asserts 2 cycles after the third press is detected (DIGIT→CHECK→result).
- OPEN lasts exactly OPEN_CYCLES cycles. Timers are $clog2(max+1) bits wide, count down, and reload on entry.
- A press in the same cycle as timer expiry: the timer wins (go to IDLE, press ignored).

## Configuration
- LOCK_CTRL_LOCKOUT_EN defined:
  - When the fail counter reaches MAX_FAILS, CHECK goes to LOCKOUT instead of IDLE.
  - In LOCKOUT: LOCKED_OUT=1 and all presses are ignored for LOCKOUT_CYCLES. Then the state goes to IDLE and the fail counter clears.
- Undefined: the LOCKOUT state, its timer and the fail counter are not built. LOCKED_OUT is tied 0 and failures always return to IDLE.

## Structure
- lock_pkg holds: the state enum (lock_state_t), SLOT_NONE=0, SLOT_FIRST=1, SLOT_LAST=3, and the digit width constant DIGIT_W=3.
- One sub-module, press_detect, performs ENTER edge detection (registered, async active-low reset).
- The down-counter timer is inline and shared between OPEN and LOCKOUT.

## Test plan
- Reset, then CREATE=1 with presses at SW=5,2,7 → three single-cycle WR_EN pulses with SLOT=1,2,3, then PW_VALID=1 and SLOT=0.
- With PW=5,2,7 and CREATE=0, enter 5,2,7 → UNLOCKED=1 two cycles after the third press, holding for OPEN_CYCLES (test with OPEN_CYCLES=20), then 0.
- Enter 5,3,7 → no early abort, a FAIL pulse after the third press, UNLOCKED stays 0.
- With LOCK_CTRL_LOCKOUT_EN, LOCKOUT_CYCLES=50: three bad attempts → LOCKED_OUT=1 for 50 cycles with presses ignored, then the correct code unlocks.
- With PW_VALID=1, CREATE=1 in IDLE → press ignored. In OPEN, CREATE=1 and a press at SW=1 → UNLOCKED drops and WR_EN fires with SLOT=1.
- Assert RST_N low after the second unlock digit → all outputs 0 immediately. After release, a fresh three-digit entry is required.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and constants for the lock box sequencing controller.
package lock_pkg;

  localparam int DIGIT_W = 3;
  localparam int SLOT_W  = 2;

  localparam logic [SLOT_W-1:0] SLOT_NONE  = 2'd0;
  localparam logic [SLOT_W-1:0] SLOT_FIRST = 2'd1;
  localparam logic [SLOT_W-1:0] SLOT_LAST  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIGIT,
    ST_CHECK,
    ST_OPEN,
    ST_LOCKOUT
  } lock_state_t;

  typedef enum logic {
    MODE_UNLOCK = 1'b0,
    MODE_CREATE = 1'b1
  } lock_mode_t;

endpackage

// File: rtl/lock_ctrl_press_detect.sv
// Rising-edge detector for the debounced ENTER level; emits a registered
// one-cycle press pulse one clock after the level is first sampled high.
module press_detect (
  input  logic CLK,
  input  logic rst_n,
  input  logic enter,
  output logic press
);

  logic enter_q;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      enter_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      enter_q <= enter;
      press   <= enter & ~enter_q;
    end
  end

endmodule

// File: rtl/lock_ctrl.sv
// Lock box sequencing controller: create/unlock sequences, open timer and
// optional lockout (build with LOCK_CTRL_LOCKOUT_EN to enable lockout).
module lock_ctrl
  import lock_pkg::*;
#(
  parameter int OPEN_CYCLES    = 500_000_000,
  parameter int LOCKOUT_CYCLES = 1_000_000_000,
  parameter int MAX_FAILS      = 3
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [DIGIT_W-1:0] SW,
  input  logic               ENTER,
  input  logic               CREATE,
  input  logic [DIGIT_W-1:0] PW1,
  input  logic [DIGIT_W-1:0] PW2,
  input  logic [DIGIT_W-1:0] PW3,
  output logic [SLOT_W-1:0]  SLOT,
  output logic               WR_EN,
  output logic               UNLOCKED,
  output logic               FAIL,
  output logic               LOCKED_OUT,
  output logic               PW_VALID
);

`ifdef LOCK_CTRL_LOCKOUT_EN
  localparam int TMR_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
`else
  localparam int TMR_MAX = OPEN_CYCLES;
`endif
  localparam int TMR_W = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYCLES - 1);

  lock_state_t        state, state_d;
  lock_mode_t         mode, mode_d;
  logic [SLOT_W-1:0]  slot, slot_d;
  logic               wr_en, wr_en_d;
  logic               consumed, consumed_d;
  logic               mismatch, mismatch_d;
  logic               pw_valid, pw_valid_d;
  logic               fail_q, fail_d;
  logic [TMR_W-1:0]   timer, timer_d;
  logic [DIGIT_W-1:0] pw_cur;
  logic               press;

`ifdef LOCK_CTRL_LOCKOUT_EN
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);

  logic [FAIL_W-1:0] fail_cnt, fail_cnt_d, fail_inc;

  function automatic logic [FAIL_W-1:0] sat_inc(input logic [FAIL_W-1:0] v);
    return (v >= FAIL_W'(MAX_FAILS)) ? v : v + 1'b1;
  endfunction

  assign fail_inc = sat_inc(fail_cnt);
`else
  logic unused_cfg;
  assign unused_cfg = ^{LOCKOUT_CYCLES, MAX_FAILS};
`endif

  press_detect u_press (
    .CLK   (CLK),
    .rst_n (RST_N),
    .enter (ENTER),
    .press (press)
  );

  always_comb begin
    case (slot)
      2'd2:    pw_cur = PW2;
      2'd3:    pw_cur = PW3;
      default: pw_cur = PW1;
    endcase
  end

  always_comb begin
    state_d    = state;
    mode_d     = mode;
    slot_d     = slot;
    wr_en_d    = 1'b0;
    consumed_d = 1'b0;
    mismatch_d = mismatch;
    pw_valid_d = pw_valid;
    fail_d     = 1'b0;
    timer_d    = timer;
`ifdef LOCK_CTRL_LOCKOUT_EN
    fail_cnt_d = fail_cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (press) begin
          if (CREATE && !pw_valid) begin
            state_d    = ST_DIGIT;
            mode_d     = MODE_CREATE;
            slot_d     = SLOT_FIRST;
            wr_en_d    = 1'b1;
            consumed_d = 1'b1;
          end else if (!CREATE && pw_valid) begin
            state_d    = ST_DIGIT;
            mode_d     = MODE_UNLOCK;
            slot_d     = SLOT_FIRST;
            consumed_d = 1'b1;
            mismatch_d = (SW != PW1);
          end
        end
      end
      ST_DIGIT: begin
        // SLOT shows the consumed digit for one cycle, then moves to the next
        if (consumed) begin
          if (slot == SLOT_LAST) begin
            pw_valid_d = 1'b1;
            slot_d     = SLOT_NONE;
            state_d    = ST_IDLE;
          end else begin
            slot_d = slot + 2'd1;
          end
        end else if (press) begin
          if (mode == MODE_CREATE) begin
            wr_en_d    = 1'b1;
            consumed_d = 1'b1;
          end else begin
            mismatch_d = mismatch | (SW != pw_cur);
            if (slot == SLOT_LAST) state_d = ST_CHECK;
            else                   consumed_d = 1'b1;
          end
        end
      end
      ST_CHECK: begin
        slot_d     = SLOT_NONE;
        mismatch_d = 1'b0;
        if (!mismatch) begin
          state_d = ST_OPEN;
          timer_d = OPEN_LOAD;
`ifdef LOCK_CTRL_LOCKOUT_EN
          fail_cnt_d = '0;
`endif
        end else begin
          fail_d  = 1'b1;
          state_d = ST_IDLE;
`ifdef LOCK_CTRL_LOCKOUT_EN
          fail_cnt_d = fail_inc;
          if (fail_inc >= FAIL_W'(MAX_FAILS)) begin
            state_d = ST_LOCKOUT;
            timer_d = LOCKOUT_LOAD;
          end
`endif
        end
      end
      ST_OPEN: begin
        // expiry takes priority over a press landing in the same cycle
        if (timer == '0) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer - 1'b1;
          if (press) begin
            if (CREATE) begin
              state_d    = ST_DIGIT;
              mode_d     = MODE_CREATE;
              slot_d     = SLOT_FIRST;
              wr_en_d    = 1'b1;
              consumed_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
`ifdef LOCK_CTRL_LOCKOUT_EN
      ST_LOCKOUT: begin
        if (timer == '0) begin
          state_d    = ST_IDLE;
          fail_cnt_d = '0;
        end else begin
          timer_d = timer - 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      mode     <= MODE_UNLOCK;
      slot     <= SLOT_NONE;
      wr_en    <= 1'b0;
      consumed <= 1'b0;
      mismatch <= 1'b0;
      pw_valid <= 1'b0;
      fail_q   <= 1'b0;
      timer    <= '0;
    end else begin
      state    <= state_d;
      mode     <= mode_d;
      slot     <= slot_d;
      wr_en    <= wr_en_d;
      consumed <= consumed_d;
      mismatch <= mismatch_d;
      pw_valid <= pw_valid_d;
      fail_q   <= fail_d;
      timer    <= timer_d;
    end
  end

`ifdef LOCK_CTRL_LOCKOUT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) fail_cnt <= '0;
    else        fail_cnt <= fail_cnt_d;
  end

  assign LOCKED_OUT = (state == ST_LOCKOUT);
`else
  assign LOCKED_OUT = 1'b0;
`endif

  assign SLOT     = slot;
  assign WR_EN    = wr_en;
  assign UNLOCKED = (state == ST_OPEN);
  assign FAIL     = fail_q;
  assign PW_VALID = pw_valid;

endmodule

// File: tb/tb_lock_ctrl.sv
// Self-checking bench for lock_ctrl: directed vector table, hand-written
// corner sequences and randomized attempts against a behavioural model.
module tb_lock_ctrl;

  localparam int OPEN_N = 20;
  localparam int LOCK_N = 50;
  localparam int MAXF   = 3;
`ifdef LOCK_CTRL_LOCKOUT_EN
  localparam bit LOCKOUT_EN = 1'b1;
`else
  localparam bit LOCKOUT_EN = 1'b0;
`endif

  logic       CLK;
  logic       RST_N;
  logic [2:0] SW;
  logic       ENTER, CREATE;
  logic [2:0] PW1, PW2, PW3;
  logic [1:0] SLOT;
  logic       WR_EN, UNLOCKED, FAIL, LOCKED_OUT, PW_VALID;

  lock_ctrl #(
    .OPEN_CYCLES    (OPEN_N),
    .LOCKOUT_CYCLES (LOCK_N),
    .MAX_FAILS      (MAXF)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .SW         (SW),
    .ENTER      (ENTER),
    .CREATE     (CREATE),
    .PW1        (PW1),
    .PW2        (PW2),
    .PW3        (PW3),
    .SLOT       (SLOT),
    .WR_EN      (WR_EN),
    .UNLOCKED   (UNLOCKED),
    .FAIL       (FAIL),
    .LOCKED_OUT (LOCKED_OUT),
    .PW_VALID   (PW_VALID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // password registers loaded by the strobe
  logic [2:0] pw_r1 = 3'd0, pw_r2 = 3'd0, pw_r3 = 3'd0;
  always @(posedge CLK) begin
    if (WR_EN) begin
      case (SLOT)
        2'd1: pw_r1 <= SW;
        2'd2: pw_r2 <= SW;
        2'd3: pw_r3 <= SW;
        default: ;
      endcase
    end
  end
  assign PW1 = pw_r1;
  assign PW2 = pw_r2;
  assign PW3 = pw_r3;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // run lengths of UNLOCKED / LOCKED_OUT and single-cycle WR_EN
  int   unl_run = 0, unl_last = 0, lo_run = 0, lo_last = 0;
  logic wr_prev = 1'b0;
  always @(negedge CLK) begin
    if (WR_EN) chk("wr_en_single_cycle", int'(wr_prev), 0);
    wr_prev = WR_EN;
    if (UNLOCKED) unl_run++;
    else if (unl_run != 0) begin unl_last = unl_run; unl_run = 0; end
    if (LOCKED_OUT) lo_run++;
    else if (lo_run != 0) begin lo_last = lo_run; lo_run = 0; end
  end

  logic       r_wr, r_wr2, r_unl, r_fl, r_lo, r_pv;
  logic [1:0] r_sl, r_sl2;

  task automatic do_press(input logic c, input logic [2:0] d);
    @(negedge CLK); SW = d; CREATE = c; ENTER = 1'b1;
    @(negedge CLK);
    @(negedge CLK); r_wr = WR_EN; r_sl = SLOT;
    @(negedge CLK);
    r_wr2 = WR_EN; r_sl2 = SLOT; r_unl = UNLOCKED; r_fl = FAIL;
    r_lo = LOCKED_OUT; r_pv = PW_VALID; ENTER = 1'b0;
    @(negedge CLK);
  endtask

  task automatic wait_unl_fall();
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK); #1;
      if (!UNLOCKED && unl_run == 0) break;
    end
    chk("unlocked_fell", int'(UNLOCKED), 0);
  endtask

  task automatic wait_lo_fall();
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK); #1;
      if (!LOCKED_OUT && lo_run == 0) break;
    end
    chk("locked_out_fell", int'(LOCKED_OUT), 0);
  endtask

  task automatic create3(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                         input bit pv0);
    logic [2:0] dg [3];
    dg[0] = a; dg[1] = b; dg[2] = c;
    for (int k = 0; k < 3; k++) begin
      do_press(1'b1, dg[k]);
      chk("create_wr", int'(r_wr), 1);
      chk("create_slot", int'(r_sl), k + 1);
      chk("create_wr_drop", int'(r_wr2), 0);
      chk("create_slot_next", int'(r_sl2), (k == 2) ? 0 : k + 2);
      chk("create_unlocked", int'(r_unl), 0);
      chk("create_pw_valid", int'(r_pv), (k == 2) ? 1 : int'(pv0));
    end
  endtask

  task automatic unlock3(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                         input bit ok, input bit exp_lo);
    logic [2:0] dg [3];
    dg[0] = a; dg[1] = b; dg[2] = c;
    for (int k = 0; k < 3; k++) begin
      do_press(1'b0, dg[k]);
      chk("unlock_wr", int'(r_wr), 0);
      chk("unlock_slot", int'(r_sl), k + 1);
      chk("unlock_slot_next", int'(r_sl2), (k == 2) ? 0 : k + 2);
      chk("unlock_unlocked", int'(r_unl), (k == 2) ? int'(ok) : 0);
      chk("unlock_fail", int'(r_fl), (k == 2) ? int'(!ok) : 0);
      chk("unlock_locked_out", int'(r_lo), (k == 2) ? int'(exp_lo) : 0);
    end
  endtask

  typedef struct {
    logic       c;
    logic [2:0] sw;
    logic       wr;
    logic [1:0] sl;
    logic [1:0] sl2;
    logic       unl;
    logic       fl;
    logic       pv;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [10];
    logic [2:0] m_pw [3];
    logic [2:0] dg [3];
    bit         m_valid, match, exp_lo;
    int         m_fails, r, r2, idx;

    tbl[0] = '{1'b1, 3'd5, 1'b1, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 3'd2, 1'b1, 2'd2, 2'd3, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 3'd7, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 3'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 3'd5, 1'b0, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 3'd3, 1'b0, 2'd2, 2'd3, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 3'd7, 1'b0, 2'd3, 2'd0, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 3'd5, 1'b0, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 3'd2, 1'b0, 2'd2, 2'd3, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 3'd7, 1'b0, 2'd3, 2'd0, 1'b1, 1'b0, 1'b1};

    RST_N = 1'b0; SW = 3'd0; ENTER = 1'b0; CREATE = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_slot", int'(SLOT), 0);
    chk("reset_wr_en", int'(WR_EN), 0);
    chk("reset_unlocked", int'(UNLOCKED), 0);
    chk("reset_fail", int'(FAIL), 0);
    chk("reset_locked_out", int'(LOCKED_OUT), 0);
    chk("reset_pw_valid", int'(PW_VALID), 0);
    RST_N = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 10; i++) begin
      do_press(tbl[i].c, tbl[i].sw);
      chk($sformatf("tbl%0d_wr", i), int'(r_wr), int'(tbl[i].wr));
      chk($sformatf("tbl%0d_slot", i), int'(r_sl), int'(tbl[i].sl));
      chk($sformatf("tbl%0d_wr_drop", i), int'(r_wr2), 0);
      chk($sformatf("tbl%0d_slot_next", i), int'(r_sl2), int'(tbl[i].sl2));
      chk($sformatf("tbl%0d_unlocked", i), int'(r_unl), int'(tbl[i].unl));
      chk($sformatf("tbl%0d_fail", i), int'(r_fl), int'(tbl[i].fl));
      chk($sformatf("tbl%0d_pw_valid", i), int'(r_pv), int'(tbl[i].pv));
    end
    wait_unl_fall();
    chk("open_duration", unl_last, OPEN_N);

    // press detected on the very cycle the open timer expires
    unlock3(3'd5, 3'd2, 3'd7, 1'b1, 1'b0);
    repeat (16) @(negedge CLK);
    do_press(1'b1, 3'd3);
    chk("expiry_press_wr", int'(r_wr), 0);
    chk("expiry_press_slot", int'(r_sl), 0);
    chk("expiry_unlocked", int'(r_unl), 0);
    wait_unl_fall();
    chk("expiry_open_duration", unl_last, OPEN_N);

    // re-create from OPEN, then relock with a CREATE=0 press
    unlock3(3'd5, 3'd2, 3'd7, 1'b1, 1'b0);
    create3(3'd1, 3'd4, 3'd6, 1'b1);
    unlock3(3'd1, 3'd4, 3'd6, 1'b1, 1'b0);
    do_press(1'b0, 3'd0);
    chk("relock_unlocked", int'(r_unl), 0);
    chk("relock_wr", int'(r_wr), 0);

    for (int a = 0; a < 3; a++)
      unlock3(3'd1, 3'd4, 3'd7, 1'b0, LOCKOUT_EN && (a == 2));
`ifdef LOCK_CTRL_LOCKOUT_EN
    do_press(1'b0, 3'd1);
    chk("lockout_press_slot", int'(r_sl), 0);
    chk("lockout_press_wr", int'(r_wr), 0);
    chk("lockout_still_active", int'(r_lo), 1);
    wait_lo_fall();
    chk("lockout_duration", lo_last, LOCK_N);
`endif
    unlock3(3'd1, 3'd4, 3'd6, 1'b1, 1'b0);
    wait_unl_fall();

    // reset in the middle of an unlock entry
    do_press(1'b0, 3'd1);
    chk("midreset_d1_slot", int'(r_sl), 1);
    do_press(1'b0, 3'd4);
    chk("midreset_d2_slot", int'(r_sl), 2);
    RST_N = 1'b0;
    #1;
    chk("midreset_slot", int'(SLOT), 0);
    chk("midreset_wr_en", int'(WR_EN), 0);
    chk("midreset_unlocked", int'(UNLOCKED), 0);
    chk("midreset_fail", int'(FAIL), 0);
    chk("midreset_locked_out", int'(LOCKED_OUT), 0);
    chk("midreset_pw_valid", int'(PW_VALID), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    do_press(1'b0, 3'd6);
    chk("postreset_unlock_ignored", int'(r_sl), 0);

    m_valid = 1'b0;
    m_fails = 0;
    for (int it = 0; it < 16; it++) begin
      if (!m_valid) begin
        for (int k = 0; k < 3; k++) m_pw[k] = 3'($urandom_range(0, 7));
        create3(m_pw[0], m_pw[1], m_pw[2], 1'b0);
        m_valid = 1'b1;
      end else begin
        r = $urandom_range(0, 3);
        if (r == 0) begin
          do_press(1'b1, 3'($urandom_range(0, 7)));
          chk("rnd_idle_create_ignored", int'(r_sl), 0);
        end else begin
          for (int k = 0; k < 3; k++) dg[k] = m_pw[k];
          if ($urandom_range(0, 1) == 1) begin
            idx = $urandom_range(0, 2);
            dg[idx] = 3'(m_pw[idx] + 3'($urandom_range(1, 7)));
          end
          match = 1'b1;
          for (int k = 0; k < 3; k++) if (dg[k] != m_pw[k]) match = 1'b0;
          if (!match) m_fails++;
          exp_lo = LOCKOUT_EN && (m_fails >= MAXF);
          unlock3(dg[0], dg[1], dg[2], match, exp_lo);
          if (match) begin
            m_fails = 0;
            r2 = $urandom_range(0, 2);
            if (r2 == 0) begin
              wait_unl_fall();
              chk("rnd_open_duration", unl_last, OPEN_N);
            end else if (r2 == 1) begin
              do_press(1'b0, 3'd0);
              chk("rnd_relock", int'(r_unl), 0);
            end else begin
              for (int k = 0; k < 3; k++) m_pw[k] = 3'($urandom_range(0, 7));
              create3(m_pw[0], m_pw[1], m_pw[2], 1'b1);
            end
          end else if (exp_lo) begin
            wait_lo_fall();
            chk("rnd_lockout_duration", lo_last, LOCK_N);
            m_fails = 0;
          end
        end
      end
    end

    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
